pipe_stage_elastic: RTL and testbench

- Parametrised, handshaked pipeline stage register that replaces the fixed load/flush inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width payload (packed pipeline struct) through a DEPTH-entry in-order buffer with a valid/ready handshake on both sides.
- Provides synchronous flush (branch/exception squash) and occupancy reporting.
- Lets hazard/stall logic back-pressure upstream stages without a combinational ready path through the stage.

---
 rtl/rv32i_types.sv | 20 ++
 rtl/pipe_buf_mem.sv | 28 ++
 rtl/pipe_stage_elastic.sv | 87 ++++++++
 tb/tb_pipe_stage_elastic.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types and stage-register defaults
package rv32i_types;

  localparam int PIPE_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_pipeline_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_we;
  } id_ex_pipeline_reg;

endpackage

// File: rtl/pipe_buf_mem.sv
// rtl/pipe_buf_mem.sv - DEPTH x WIDTH register array, one write port, async read
module pipe_buf_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - handshaked in-order pipeline stage register with flush
module pipe_stage_elastic
  import rv32i_types::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = PIPE_DEPTH_DEFAULT,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  // Explicit wrap so non-power-of-2 depths cycle through exactly DEPTH slots
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    count_next  = count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (flush) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wrap_inc(wr_ptr);
      if (pop)  rd_ptr_next = wrap_inc(rd_ptr);
      if (push && !pop)      count_next = count + CW'(1);
      else if (pop && !push) count_next = count - CW'(1);
    end
  end

  // in_ready is a flop so upstream never sees a path from out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_next;
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      in_ready <= (count_next < FULL);
    end
  end

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .clear (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign out_data = (ZERO_BUBBLE && !out_valid) ? '0 : head;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for DEPTH 2, 3 and 1 stage instances
module tb_pipe_stage_elastic;

  logic        clk;
  logic        rst;
  logic        flush     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] in_data   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] out_data  [3];
  logic [1:0]  count0, count1;
  logic [0:0]  count2;
  int          cnt [3];
  int          dep [3] = '{2, 3, 1};
  logic        pushed [3];

  logic [31:0] q0[$], q1[$], q2[$];
  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .ZERO_BUBBLE(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .count(count0));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(3), .ZERO_BUBBLE(1'b1)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .count(count1));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(1), .ZERO_BUBBLE(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .count(count2));

  always_comb begin
    cnt[0] = int'(count0);
    cnt[1] = int'(count1);
    cnt[2] = int'(count2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qfront(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int k, input logic [31:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qclear(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Check every instance against its queue, update the model, advance one cycle
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      int   sz;
      logic mready;
      sz     = qsize(k);
      mready = (sz < dep[k]);
      chk("count", k, cnt[k], sz);
      chk("out_valid", k, {31'b0, out_valid[k]}, {31'b0, sz != 0});
      chk("in_ready", k, {31'b0, in_ready[k]}, {31'b0, mready});
      chk("out_data", k, out_data[k], (sz != 0) ? qfront(k) : 32'h0);
      pushed[k] = 1'b0;
      if (flush[k]) begin
        qclear(k);
      end else begin
        if (out_ready[k] && sz != 0) qpop(k);
        if (in_valid[k] && mready) begin
          qpush(k, in_data[k]);
          pushed[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      flush[k] = 0; in_valid[k] = 0; in_data[k] = 0; out_ready[k] = 0; pushed[k] = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    tick();

    // Streaming through DEPTH=2 with downstream always ready
    out_ready[0] = 1; in_valid[0] = 1;
    in_data[0] = 32'h11; tick();
    in_data[0] = 32'h22; tick();
    in_data[0] = 32'h33; tick();
    in_valid[0] = 0; tick(); tick();

    // Back-pressure: fill, stall the third item, then drain in order
    out_ready[0] = 0; in_valid[0] = 1;
    in_data[0] = 32'hA; tick();
    in_data[0] = 32'hB; tick();
    in_data[0] = 32'hC; tick(); tick();
    out_ready[0] = 1; tick(); tick();
    in_valid[0] = 0; tick(); tick(); tick();

    // Flush while full, with a competing input that must vanish
    out_ready[0] = 0; in_valid[0] = 1;
    in_data[0] = 32'h5; tick();
    in_data[0] = 32'h6; tick();
    flush[0] = 1; in_data[0] = 32'h7; tick();
    flush[0] = 0; in_valid[0] = 0; out_ready[0] = 1; tick(); tick();

    // Asynchronous reset mid-cycle with an entry held in each instance
    out_ready[0] = 0; in_valid[0] = 1; in_data[0] = 32'hDEAD;
    in_valid[1] = 1; in_data[1] = 32'hBEEF;
    in_valid[2] = 1; in_data[2] = 32'hCAFE;
    tick();
    in_valid[0] = 0; in_valid[1] = 0; in_valid[2] = 0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_count", k, cnt[k], 0);
      chk("rst_out_valid", k, {31'b0, out_valid[k]}, 32'h0);
      chk("rst_in_ready", k, {31'b0, in_ready[k]}, 32'h1);
      chk("rst_out_data", k, out_data[k], 32'h0);
      qclear(k);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick();

    // DEPTH=3 random traffic, holding in_valid until accepted
    in_valid[1] = 1; in_data[1] = $urandom; out_ready[1] = 1'($urandom_range(0, 1));
    repeat (40) begin
      tick();
      if (pushed[1] || !in_valid[1]) begin
        in_valid[1] = ($urandom_range(0, 3) != 0);
        in_data[1]  = $urandom;
      end
      out_ready[1] = 1'($urandom_range(0, 1));
    end
    in_valid[1] = 0; out_ready[1] = 1;
    repeat (4) tick();

    // DEPTH=1 continuous traffic: one accept every other cycle
    in_valid[2] = 1; out_ready[2] = 1; in_data[2] = 32'h100;
    repeat (10) begin
      tick();
      if (pushed[2]) in_data[2] = in_data[2] + 32'h1;
    end
    in_valid[2] = 0;
    repeat (2) tick();
    chk("d1_accepted", 2, in_data[2], 32'h105);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
